pipe_cla_adder: RTL
===================

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter BLOCK, default 8, lookahead slice width; WIDTH SHALL be an integer multiple of BLOCK; STAGES = WIDTH/BLOCK.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand set presented.
REQ-006 SHALL have port in_ready  output  1  block can accept the operand set this cycle.
REQ-007 SHALL have ports data_operandA, data_operandB  input  WIDTH  operands.
REQ-008 SHALL have port c_in  input  1  carry-in, used when sub=0.
REQ-009 SHALL have port sub  input  1  1 = A minus B.
REQ-010 SHALL have port out_valid  output  1  result registers hold a valid result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-012 SHALL have port data_result  output  WIDTH  sum/difference.
REQ-013 SHALL have port c_out  output  1  carry out of MSB.
REQ-014 SHALL have port overflow  output  1  signed overflow; exists only under the macro in REQ-030.

Function
REQ-015 SHALL use effective B = sub ? ~data_operandB : data_operandB and effective carry-in = sub ? 1 : c_in.
REQ-016 SHALL be a STAGES-deep pipeline; stage k (0-based) SHALL add bits [k*BLOCK +: BLOCK] using BLOCK-bit carry lookahead (generate/propagate) with the carry registered from stage k-1; stage 0 SHALL use the effective carry-in.
REQ-017 SHALL skew operands: unconsumed upper slices SHALL be registered forward with each stage; completed lower result slices SHALL be registered forward unchanged.
REQ-018 SHALL keep a valid bit per stage; the last stage's valid bit SHALL drive out_valid.
REQ-019 SHALL define advance = !out_valid || out_ready; in_ready SHALL equal advance, combinationally.
REQ-020 On advance, every stage SHALL load from its predecessor and stage 0 SHALL load valid = in_valid; on !advance, all stage registers including valid bits SHALL hold.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance (in_valid && in_ready at edge n) to out_valid at edge n+STAGES, with no stalls; throughput SHALL be one operation per cycle.
REQ-022 data_result and c_out SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 Results SHALL emerge in acceptance order; no operation SHALL be lost or duplicated under any out_ready pattern.
REQ-024 Result SHALL be modulo 2^WIDTH; c_out SHALL be the raw carry of A + effective B + effective carry-in (for sub, c_out=1 means no borrow).
REQ-025 Bubbles (in_valid=0 on advance) SHALL propagate as invalid stages without affecting neighbouring valid operations.
REQ-026 Simultaneous out_ready and in_valid with a full pipe SHALL retire one result and accept one operand on the same edge.

Reset
REQ-027 On reset=1 at a rising edge, all stage valid bits SHALL clear; out_valid=0, data_result=0, c_out=0, overflow=0 after that edge.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; in_ready SHALL be 1 during and after the reset cycle.
REQ-029 Datapath registers other than outputs need not be cleared but SHALL NOT produce out_valid=1 until new operations are accepted after reset.

Configuration
REQ-030 With macro PIPE_CLA_OVERFLOW_EN defined, port overflow SHALL exist and equal, for the output result, (A[MSB] == effB[MSB]) && (result[MSB] != A[MSB]), with operand sign bits carried through the pipe; without the macro, the port and its sign-bit pipeline registers SHALL NOT exist.

Verification (WIDTH=32, BLOCK=8, out_ready=1 unless stated)
REQ-031 A=0xFFFFFFFF, B=0, c_in=1, sub=0 accepted at edge n -> out_valid at edge n+4, result 0x00000000, c_out=1.
REQ-032 A=5, B=7, sub=1 -> result 0xFFFFFFFE, c_out=0; A=7, B=5, sub=1 -> result 0x00000002, c_out=1.
REQ-033 With PIPE_CLA_OVERFLOW_EN: A=0x7FFFFFFF, B=1, c_in=0 -> result 0x80000000, overflow=1; A=0x80000000, B=1, sub=1 -> result 0x7FFFFFFF, overflow=1.
REQ-034 Six back-to-back operations A=i, B=i (i=1..6), out_ready=0 for cycles 3-8 -> in_ready low once out_valid=1, results 2,4,6,8,10,12 in order, each held stable while stalled.
REQ-035 Accept three operations, assert reset for one cycle two cycles later -> out_valid stays 0 for 5 cycles afterwards; next accepted A=1, B=1 yields result 2 exactly 4 cycles later.
REQ-036 Alternate in_valid 1/0 with A=0x00FF00FF, B=0x00010001, c_in=0 -> results 0x01000100, c_out=0, each with exactly one bubble cycle between.

Source files
------------

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder
//   Pipelined adder/subtractor. The operands are split into STAGES slices of
//   BLOCK bits each. Every pipeline stage adds one slice with a flat
//   carry-lookahead network and registers the carry for the next stage.
//   Operands are skewed: the slices that are still unconsumed move forward
//   with each stage, and the finished lower result slices move forward
//   unchanged. A result appears STAGES cycles after its operands are
//   accepted. Throughput is one operation per cycle, with valid/ready flow
//   control on both sides.
//
// Parameters
//   WIDTH   operand/result width (must be a multiple of BLOCK)
//   BLOCK   lookahead slice width
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous active-high reset
//   in_valid       operand set presented
//   in_ready       operand set can be accepted this cycle
//   data_operandA  operand A
//   data_operandB  operand B
//   c_in           carry-in for addition (ignored when sub=1)
//   sub            1 = A minus B
//   out_valid      data_result/c_out hold a valid result
//   out_ready      consumer takes the result this cycle
//   data_result    sum or difference, modulo 2^WIDTH
//   c_out          raw carry out of the MSB (for subtraction, 1 = no borrow)
//   overflow       signed overflow of the output result; present only when
//                  the macro PIPE_CLA_OVERFLOW_EN is defined
module pipe_cla_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             c_out
`ifdef PIPE_CLA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int STAGES = WIDTH / BLOCK;

  // Refuse to build with a width that does not divide into whole slices.
  if ((WIDTH % BLOCK) != 0 || STAGES < 1) begin : g_param_check
    $error("pipe_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  // One BLOCK-bit carry-lookahead slice. The carry into each bit is built
  // from generate/propagate terms as a flat sum of products, so it does not
  // ripple through the lower bits. The result is {carry_out, sum}.
  function automatic logic [BLOCK:0] cla_slice(
    input logic [BLOCK-1:0] a,
    input logic [BLOCK-1:0] b,
    input logic             cin
  );
    logic [BLOCK-1:0] gen;
    logic [BLOCK-1:0] prop;
    logic [BLOCK:0]   carry;
    logic             term;
    gen      = a & b;
    prop     = a ^ b;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      carry[i+1] = gen[i];
      term       = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        carry[i+1] = carry[i+1] | (term & gen[j]);
        term       = term & prop[j];
      end
      carry[i+1] = carry[i+1] | (term & cin);
    end
    return {carry[BLOCK], prop ^ carry[BLOCK-1:0]};
  endfunction

  // Pipeline registers. Index 0 captures the operands. Index k+1 holds the
  // output of stage k, so index STAGES is the output register.
  // In word_q[k], the bits below k*BLOCK are finished sum slices and the
  // remaining upper bits are still operand A.
  logic             valid_q [STAGES+1];
  logic [WIDTH-1:0] word_q  [STAGES+1];
  logic             carry_q [STAGES+1];
  logic [WIDTH-1:0] opb_q   [STAGES];
`ifdef PIPE_CLA_OVERFLOW_EN
  logic             sign_a_q [STAGES+1];
  logic             sign_b_q [STAGES+1];
`endif

  logic             advance;
  logic [WIDTH-1:0] eff_b;
  logic             eff_cin;
  logic [WIDTH-1:0] stage_word  [STAGES];
  logic             stage_carry [STAGES];

  // Subtraction is A + ~B + 1. The inversion and the forced carry are
  // applied once at the input, so every stage is a plain adder.
  always_comb begin
    eff_b   = sub ? ~data_operandB : data_operandB;
    eff_cin = sub ? 1'b1 : c_in;
  end

  // The whole pipe moves together, or holds when the output is blocked.
  // in_ready also stays high while reset is asserted, because whatever is
  // presented during reset is discarded anyway.
  always_comb begin
    advance  = !out_valid || out_ready;
    in_ready = advance || reset;
  end

  // Slice adders. Stage k consumes slice k of its word and writes the sum
  // back into the same bit positions, leaving all other bits untouched.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      logic [BLOCK:0] slice;
      slice          = cla_slice(word_q[k][k*BLOCK +: BLOCK],
                                 opb_q[k][k*BLOCK +: BLOCK],
                                 carry_q[k]);
      stage_word[k]  = word_q[k];
      stage_word[k][k*BLOCK +: BLOCK] = slice[BLOCK-1:0];
      stage_carry[k] = slice[BLOCK];
    end
  end

  // Pipeline advance. Reset clears every valid bit and also clears the
  // output register, so the visible outputs read zero. The internal
  // datapath is left as it is, because the cleared valid bits already mark
  // it as empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k <= STAGES; k++) begin
        valid_q[k] <= 1'b0;
      end
      word_q[STAGES]   <= '0;
      carry_q[STAGES]  <= 1'b0;
`ifdef PIPE_CLA_OVERFLOW_EN
      sign_a_q[STAGES] <= 1'b0;
      sign_b_q[STAGES] <= 1'b0;
`endif
    end else if (advance) begin
      valid_q[0] <= in_valid;
      word_q[0]  <= data_operandA;
      opb_q[0]   <= eff_b;
      carry_q[0] <= eff_cin;
`ifdef PIPE_CLA_OVERFLOW_EN
      sign_a_q[0] <= data_operandA[WIDTH-1];
      sign_b_q[0] <= eff_b[WIDTH-1];
`endif
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k+1] <= valid_q[k];
        word_q[k+1]  <= stage_word[k];
        carry_q[k+1] <= stage_carry[k];
`ifdef PIPE_CLA_OVERFLOW_EN
        sign_a_q[k+1] <= sign_a_q[k];
        sign_b_q[k+1] <= sign_b_q[k];
`endif
      end
      for (int k = 1; k < STAGES; k++) begin
        opb_q[k] <= opb_q[k-1];
      end
    end
  end

  // After the last stage every slice of the word is a finished sum.
  always_comb begin
    out_valid   = valid_q[STAGES];
    data_result = word_q[STAGES];
    c_out       = carry_q[STAGES];
  end

`ifdef PIPE_CLA_OVERFLOW_EN
  // Signed overflow: both operands have the same sign, but the result sign
  // is different. The sign of B here is the sign after inversion for
  // subtraction.
  always_comb begin
    overflow = (sign_a_q[STAGES] == sign_b_q[STAGES]) &&
               (data_result[WIDTH-1] != sign_a_q[STAGES]);
  end
`endif

endmodule
